// File: rtl/uart_frame_ctrl_if.sv
// Byte-receiver side and bank-write side of the UART frame sequencer.
// master: the stimulus/receiver side; slave: the frame controller itself.
interface uart_frame_ctrl_if #(
  parameter int unsigned MAX_BYTES = 32
) ();
  logic [7:0]             rx_data;
  logic                   rx_valid;
  logic                   rx_ferr;
  logic [8*MAX_BYTES-1:0] data_out;
  logic                   data_write;
  logic [7:0]             bank;
  logic                   frame_err;
  logic                   busy;

  modport master (
    output rx_data, rx_valid, rx_ferr,
    input  data_out, data_write, bank, frame_err, busy
  );

  modport slave (
    input  rx_data, rx_valid, rx_ferr,
    output data_out, data_write, bank, frame_err, busy
  );
endinterface

// File: rtl/uart_frame_ctrl.sv
// Frame sequencer: parses '<' B1 B0 D0..Dn-1 '>' from the UART byte stream, collects the payload
// in a shadow buffer and commits data_out/bank atomically with a one-cycle data_write strobe.
// Malformed, interrupted or stalled frames are dropped and flagged with a one-cycle frame_err.
module uart_frame_ctrl #(
  parameter int unsigned MAX_BYTES   = 32,
  parameter int unsigned TIMEOUT_CYC = 2000
) (
  input logic               clk,
  input logic               rst,
  uart_frame_ctrl_if.slave  bus
);

  localparam int unsigned DW = 8 * MAX_BYTES;
  localparam int unsigned CW = $clog2(MAX_BYTES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [7:0] SOF = 8'h3C;  // '<'
  localparam logic [7:0] EOF = 8'h3E;  // '>'

  typedef enum logic [1:0] {StIdle, StBankHi, StBankLo, StData} state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   shadow_q;
  logic [CW-1:0]   count_q;
  logic [TW-1:0]   tmo_q;
  logic [3:0]      hi_q, lo_q;
  logic [DW-1:0]   data_out_q;
  logic [7:0]      bank_q;
  logic            data_write_q, frame_err_q, busy_q;

  logic            is_digit;
  logic            abort, commit, push, restart, hi_ld, lo_ld;
  logic [7:0]      bank_val;

  assign is_digit = (bus.rx_data >= 8'h30) && (bus.rx_data <= 8'h39);
  assign bank_val = ({4'd0, hi_q} * 8'd10) + {4'd0, lo_q};

  // Decode the current byte (or timeout) into next state and datapath actions.
  always_comb begin
    state_d = state_q;
    abort   = 1'b0;
    commit  = 1'b0;
    push    = 1'b0;
    restart = 1'b0;
    hi_ld   = 1'b0;
    lo_ld   = 1'b0;
    if (bus.rx_valid) begin
      if (bus.rx_ferr) begin
        // A corrupted byte only matters once a frame is open.
        if (state_q != StIdle) abort = 1'b1;
      end else if (bus.rx_data == SOF) begin
        restart = 1'b1;
        state_d = StBankHi;
      end else begin
        unique case (state_q)
          StIdle: begin
          end
          StBankHi: begin
            if (is_digit) begin
              hi_ld   = 1'b1;
              state_d = StBankLo;
            end else begin
              abort = 1'b1;
            end
          end
          StBankLo: begin
            if (is_digit) begin
              lo_ld   = 1'b1;
              state_d = StData;
            end else begin
              abort = 1'b1;
            end
          end
          StData: begin
            if (bus.rx_data == EOF) begin
              if (count_q != '0) commit = 1'b1;
              else               abort  = 1'b1;
            end else if (count_q < CW'(MAX_BYTES)) begin
              push = 1'b1;
            end else begin
              abort = 1'b1;
            end
          end
        endcase
      end
    end else if ((state_q != StIdle) && (tmo_q == TW'(TIMEOUT_CYC - 1))) begin
      // Last allowed idle cycle passes without a byte.
      abort = 1'b1;
    end
    if (abort || commit) state_d = StIdle;
  end

  // Frame FSM, payload buffer, timeout counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      shadow_q     <= '0;
      count_q      <= '0;
      tmo_q        <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      data_out_q   <= '0;
      bank_q       <= '0;
      data_write_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_q       <= (state_d != StIdle);
      data_write_q <= commit;
      // A '<' inside an open frame loses the previous frame.
      frame_err_q  <= abort || (restart && (state_q != StIdle));

      if (bus.rx_valid || (state_d == StIdle)) tmo_q <= '0;
      else                                     tmo_q <= tmo_q + TW'(1);

      if (abort || restart || commit) begin
        shadow_q <= '0;
        count_q  <= '0;
      end else if (push) begin
        shadow_q <= {shadow_q[DW-9:0], bus.rx_data};
        count_q  <= count_q + CW'(1);
      end

      if (hi_ld) hi_q <= bus.rx_data[3:0];
      if (lo_ld) lo_q <= bus.rx_data[3:0];

      if (commit) begin
        data_out_q <= shadow_q;
        bank_q     <= bank_val;
      end
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.bank       = bank_q;
  assign bus.data_write = data_write_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Scoreboard bench for uart_frame_ctrl: stimulus pushes expected commit/abort events,
// a negedge monitor pops and compares whenever data_write or frame_err fires.
module tb_uart_frame_ctrl;

  localparam int unsigned MAXB = 32;
  localparam int unsigned TMO  = 2000;

  typedef struct {
    bit           is_commit;
    logic [7:0]   bank;
    logic [255:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];

  uart_frame_ctrl_if #(.MAX_BYTES(MAXB)) u_if ();

  uart_frame_ctrl #(
    .MAX_BYTES  (MAXB),
    .TIMEOUT_CYC(TMO)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(u_if.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic push_commit(input logic [7:0] b, input logic [255:0] d);
    exp_t e;
    e.is_commit = 1'b1;
    e.bank      = b;
    e.data      = d;
    exp_q.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e.is_commit = 1'b0;
    e.bank      = '0;
    e.data      = '0;
    exp_q.push_back(e);
  endtask

  // Called at posedge+1; leaves at the next posedge+1.
  task automatic send(input logic [7:0] b, input logic ferr = 1'b0);
    u_if.rx_data  = b;
    u_if.rx_valid = 1'b1;
    u_if.rx_ferr  = ferr;
    @(posedge clk);
    #1;
    u_if.rx_valid = 1'b0;
    u_if.rx_ferr  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (u_if.data_write) begin
      if (exp_q.size() == 0 || !exp_q[0].is_commit) begin
        total++;
        bad++;
        $display("FAIL commit_unexpected: got data_write=1 bank=%0d required no commit",
                 u_if.bank);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end else begin
        check("commit_bank", 256'(u_if.bank), 256'(exp_q[0].bank));
        check("commit_data", u_if.data_out, exp_q[0].data);
        void'(exp_q.pop_front());
      end
    end
    if (u_if.frame_err) begin
      if (exp_q.size() == 0 || exp_q[0].is_commit) begin
        total++;
        bad++;
        $display("FAIL frame_err_unexpected: got frame_err=1 required no abort");
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end else begin
        total++;
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [255:0] all41;
    all41 = {32{8'h41}};

    rst           = 1'b1;
    u_if.rx_data  = 8'h00;
    u_if.rx_valid = 1'b0;
    u_if.rx_ferr  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_data_out", u_if.data_out, '0);
    check("reset_bank", 256'(u_if.bank), 256'd0);
    check("reset_strobes", 256'({u_if.data_write, u_if.frame_err, u_if.busy}), 256'd0);
    rst = 1'b0;
    idle(2);

    // T1: basic frame, bank 01, payload "20"
    send(8'h3C);
    check("t1_busy_after_sof", 256'(u_if.busy), 256'd1);
    send("0"); send("1"); send("2"); send("0");
    push_commit(8'd1, 256'h3230);
    send(8'h3E);
    check("t1_busy_after_commit", 256'(u_if.busy), 256'd0);
    idle(3);

    // T2: full 32-byte payload, then a 33-byte payload aborts
    send(8'h3C); send("9"); send("9");
    for (int i = 0; i < 32; i++) send(8'h41);
    push_commit(8'd99, all41);
    send(8'h3E);
    idle(2);
    send(8'h3C); send("9"); send("9");
    for (int i = 0; i < 32; i++) send(8'h42);
    push_err();
    send(8'h42);
    send(8'h3E);  // lands in IDLE, ignored
    idle(2);
    check("t2_data_kept", u_if.data_out, all41);
    check("t2_bank_kept", 256'(u_if.bank), 256'd99);

    // T3: bad bank digit, then a good frame
    send(8'h3C);
    push_err();
    send("A");
    check("t3_busy_drop", 256'(u_if.busy), 256'd0);
    idle(2);
    send(8'h3C); send("0"); send("2"); send("5");
    push_commit(8'd2, 256'h35);
    send(8'h3E);
    idle(2);

    // T4: timeout at exactly TMO idle cycles; TMO-1 gap still commits
    send(8'h3C); send("0"); send("3"); send("7");
    push_err();
    idle(TMO);
    check("t4_idle_after_timeout", 256'(u_if.busy), 256'd0);
    idle(2);
    send(8'h3C); send("0"); send("3"); send("7");
    idle(TMO - 1);
    check("t4_busy_before_expiry", 256'(u_if.busy), 256'd1);
    push_commit(8'd3, 256'h37);
    send(8'h3E);
    idle(2);

    // T5: '<' restarts an open frame
    send(8'h3C); send("0"); send("1"); send("x");
    push_err();
    send(8'h3C);
    send("0"); send("4"); send("y");
    push_commit(8'd4, 256'h79);
    send(8'h3E);
    idle(2);

    // T6: reset mid-frame, then framing error on '>'
    send(8'h3C); send("0"); send("5"); send("a");
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("t6_rst_data_out", u_if.data_out, '0);
    check("t6_rst_bank", 256'(u_if.bank), 256'd0);
    check("t6_rst_strobes", 256'({u_if.data_write, u_if.frame_err, u_if.busy}), 256'd0);
    idle(2);
    send(8'h3C); send("0"); send("6"); send("b");
    push_err();
    send(8'h3E, 1'b1);
    idle(3);
    check("t6_ferr_no_commit", u_if.data_out, '0);
    check("t6_ferr_bank", 256'(u_if.bank), 256'd0);

    idle(5);
    check("scoreboard_drained", 256'(exp_q.size()), 256'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
